// File: rtl/enc_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
// Shared constants and types for the turbo-encoder front end.
//   K_SMALL / K_LARGE : supported code-block lengths in bits
//   CNT_W             : bit-counter width (holds 0..K_LARGE)
//   CRC24B_POLY       : CRC24B generator without the implicit x^24 term
//   bank_state_t      : ping-pong bank occupancy
//   rd_state_t        : readout FSM state
//   blk_len()         : block length on the output side for a size flag
//   fill_len()        : number of bits the input supplies per block
// Build option: CBS_CRC24B_EN makes fill_len() 24 bits shorter than
// blk_len(), because the CRC tail is generated locally.
// ----------------------------------------------------------------------------
package enc_pkg;

    localparam int K_SMALL = 1056;
    localparam int K_LARGE = 6144;
    localparam int CNT_W   = 13;
    localparam int CRC_W   = 24;
    localparam logic [CRC_W-1:0] CRC24B_POLY = 24'h800063;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_START  = 2'd1,
        R_STREAM = 2'd2
    } rd_state_t;

    function automatic logic [CNT_W-1:0] blk_len(input logic size);
        return size ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
    endfunction

    function automatic logic [CNT_W-1:0] fill_len(input logic size);
`ifdef CBS_CRC24B_EN
        return blk_len(size) - CNT_W'(CRC_W);
`else
        return blk_len(size);
`endif
    endfunction

endpackage

// File: rtl/cbs_crc24b.sv
// ----------------------------------------------------------------------------
// cbs_crc24b
// Serial CRC24B LFSR (init 0, MSB-first message order). The register only
// moves while en is high, so once the owning bank stops filling the value
// stays frozen until the next clr.
// Ports:
//   clock, aclr : clock, asynchronous active-high reset
//   clr         : restart the CRC; when combined with en, din is the first bit
//   en          : absorb din this cycle
//   din         : message bit
//   crc         : current remainder
// Only built when CBS_CRC24B_EN is defined.
// ----------------------------------------------------------------------------
module cbs_crc24b
    import enc_pkg::*;
(
    input  logic             clock,
    input  logic             aclr,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] crc_next;
    logic             fb;

    always_comb begin
        base     = clr ? '0 : crc;
        fb       = base[CRC_W-1] ^ din;
        crc_next = {base[CRC_W-2:0], 1'b0} ^ (fb ? CRC24B_POLY : '0);
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_next;
        end else if (clr) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/cbs_block_buffer.sv
// ----------------------------------------------------------------------------
// cbs_block_buffer
// Two-bank ping-pong code-block buffer in front of the turbo encoder. A
// bit-serial block is written into wr_bank; once a bank is FULL and the
// encoder is idle, the block is replayed one bit per cycle from rd_bank.
// Filling one bank overlaps with reading the other.
// Ports:
//   clock, aclr            : clock, asynchronous active-high reset
//   in_valid/in_bit/in_sob : input bit stream, in_sob marks bit 0
//   in_size                : sampled with in_sob, 0=K_SMALL 1=K_LARGE
//   in_ready               : current write bank is not FULL
//   enc_ready              : encoder idle, only looked at in R_IDLE
//   cbs_ready              : one-cycle pulse, a block replay starts
//   cbs_size               : size of the block being replayed
//   cbs_valid/cbs_bit      : replay stream, K contiguous bits
//   cbs_last               : marks bit K-1 of the replay
//   seg_err                : sticky framing error flag
// Handshake: an input bit is transferred in every cycle where
// in_valid && in_ready; there is no backpressure on the output side.
// Build option: CBS_CRC24B_EN -- input carries K-24 bits, the replay
// appends a locally computed CRC24B (MSB first) as the last 24 bits.
// ----------------------------------------------------------------------------
module cbs_block_buffer
    import enc_pkg::*;
(
    input  logic clock,
    input  logic aclr,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_sob,
    input  logic in_size,
    output logic in_ready,
    input  logic enc_ready,
    output logic cbs_ready,
    output logic cbs_size,
    output logic cbs_valid,
    output logic cbs_bit,
    output logic cbs_last,
    output logic seg_err
);

    bank_state_t      bank_st   [2];
    logic             bank_size [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] rd_len;
    logic [CNT_W-1:0] wr_addr;
    logic [CNT_W-1:0] rd_addr;
    rd_state_t        rd_state;
    rd_state_t        rd_next;

    logic             mem [2][K_LARGE];
    logic             ram_q;

    logic             accept;
    logic             wr_en;
    logic             wr_done;
    logic             sob_restart;
    logic             stray;
    logic             rd_done;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign in_ready    = (bank_st[wr_bank] != FULL);
    assign accept      = in_valid & in_ready;
    assign sob_restart = accept & in_sob & (bank_st[wr_bank] == FILLING);
    assign stray       = accept & ~in_sob & (bank_st[wr_bank] == EMPTY);
    assign wr_en       = accept & (in_sob | (bank_st[wr_bank] == FILLING));
    assign wr_addr     = in_sob ? '0 : wr_cnt;
    // bit 0 always comes with in_sob, so completion is never on an sob bit
    assign wr_done     = wr_en & ~in_sob &
                         (wr_cnt == fill_len(bank_size[wr_bank]) - CNT_W'(1));

    // Bank bookkeeping. The read side only frees a FULL bank while the write
    // side only touches a non-FULL bank, so the two never hit one entry.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            bank_st[0]   <= EMPTY;
            bank_st[1]   <= EMPTY;
            bank_size[0] <= 1'b0;
            bank_size[1] <= 1'b0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_cnt       <= '0;
            seg_err      <= 1'b0;
        end else begin
            if (sob_restart || stray) begin
                seg_err <= 1'b1;
            end
            if (wr_en) begin
                if (in_sob) begin
                    // a restart simply overwrites the partial block
                    bank_st[wr_bank]   <= FILLING;
                    bank_size[wr_bank] <= in_size;
                    wr_cnt             <= CNT_W'(1);
                end else if (wr_done) begin
                    bank_st[wr_bank] <= FULL;
                    wr_bank          <= ~wr_bank;
                    wr_cnt           <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
            if (rd_done) begin
                bank_st[rd_bank] <= EMPTY;
                rd_bank          <= ~rd_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    assign rd_len = blk_len(bank_size[rd_bank]);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // The RAM has one cycle of read latency: R_START issues address 0 and
    // each R_STREAM cycle issues the address of the following bit.
    always_comb begin
        rd_next   = rd_state;
        rd_done   = 1'b0;
        rd_addr   = '0;
        cbs_ready = 1'b0;
        cbs_valid = 1'b0;
        cbs_last  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (bank_st[rd_bank] == FULL && enc_ready) begin
                    rd_next = R_START;
                end
            end
            R_START: begin
                cbs_ready = 1'b1;
                rd_next   = R_STREAM;
            end
            R_STREAM: begin
                cbs_valid = 1'b1;
                if (rd_cnt == rd_len - CNT_W'(1)) begin
                    cbs_last = 1'b1;
                    rd_done  = 1'b1;
                    rd_next  = R_IDLE;
                end else begin
                    rd_addr = rd_cnt + CNT_W'(1);
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rd_cnt <= '0;
        end else if (rd_state == R_STREAM) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
        end else begin
            rd_cnt <= '0;
        end
    end

    assign cbs_size = (rd_state != R_IDLE) ? bank_size[rd_bank] : 1'b0;

    // ------------------------------------------------------------------
    // Bank storage: plain synchronous RAM, no reset
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= in_bit;
        end
        ram_q <= mem[rd_bank][rd_addr];
    end

`ifdef CBS_CRC24B_EN
    logic [CRC_W-1:0] crc_bank [2];
    logic [CNT_W-1:0] tail_start;
    logic [4:0]       crc_sel;

    for (genvar b = 0; b < 2; b++) begin : g_crc
        cbs_crc24b u_crc (
            .clock (clock),
            .aclr  (aclr),
            .clr   (wr_en & in_sob & (wr_bank == 1'(b))),
            .en    (wr_en & (wr_bank == 1'(b))),
            .din   (in_bit),
            .crc   (crc_bank[b])
        );
    end

    // Last 24 replay positions come from the frozen CRC of the read bank.
    always_comb begin
        tail_start = rd_len - CNT_W'(CRC_W);
        crc_sel    = 5'(CNT_W'(CRC_W - 1) - (rd_cnt - tail_start));
        cbs_bit    = cbs_valid &
                     ((rd_cnt >= tail_start) ? crc_bank[rd_bank][crc_sel] : ram_q);
    end
`else
    assign cbs_bit = cbs_valid & ram_q;
`endif

endmodule
